// File: rtl/mul_pkg.sv
// Shared types and constants for the seq_mul multiplier: controller states
// and the per-operation algorithm select encoding.
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_REPADD = 1'b0;
  localparam logic MODE_SHIFT  = 1'b1;

endpackage

// File: rtl/mul_cntr.sv
// Loadable multiplier-operand register with decrement and shift-right
// controls; reports its LSB and an equal-zero flag for loop termination.
module mul_cntr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic             shr,
  input  logic [WIDTH-1:0] d,
  output logic             lsb,
  output logic             zero
);

  logic [WIDTH-1:0] q;

  // load wins over dec, and dec over shr; the controller never asserts two at once
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (dec) begin
      q <= q - 1'b1;
    end else if (shr) begin
      q <= q >> 1;
    end
  end

  assign lsb  = q[0];
  assign zero = (q == '0);

endmodule

// File: rtl/seq_mul.sv
// Sequential unsigned multiplier: repeated-add or shift-add selected per
// operation, one shared adder, Moore busy/done outputs.
module seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;

  // Handshake: start is taken only while busy is low (IDLE), operands and mode
  // are captured at that same edge; busy stays high through RUN and DONE, and
  // done is a single-cycle pulse after which product is valid and held.

  state_t        state;
  logic [PW-1:0] a_reg;
  logic          mode_reg;
  logic          b_lsb;
  logic          b_zero;
  logic          load;
  logic          stop;
  logic          step;
  logic          dec_en;
  logic          shr_en;
  logic          add_en;
  logic [PW-1:0] sum;

  assign load   = (state == S_IDLE) && start;
  assign stop   = b_zero || (a_reg == '0);
  assign step   = (state == S_RUN) && !stop;
  assign dec_en = step && (mode_reg == MODE_REPADD);
  assign shr_en = step && (mode_reg == MODE_SHIFT);
  assign add_en = step && ((mode_reg == MODE_REPADD) || b_lsb);
  assign sum    = product + a_reg;

  mul_cntr #(
    .WIDTH (WIDTH)
  ) u_cntr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .dec  (dec_en),
    .shr  (shr_en),
    .d    (b_in),
    .lsb  (b_lsb),
    .zero (b_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      a_reg    <= '0;
      mode_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg    <= {{WIDTH{1'b0}}, a_in};
            mode_reg <= mode;
            product  <= '0;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            if (add_en) begin
              product <= sum;
            end
            // bits pushed past the top are dropped; b_reg is zero before that matters
            if (mode_reg == MODE_SHIFT) begin
              a_reg <= a_reg << 1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised sequential multiplier and the next generation of the team's repeated-addition multiplier datapath/controller pair. It accepts two unsigned WIDTH-bit operands on a start pulse and produces a full-precision 2*WIDTH-bit product. The per-operation mode selects either the legacy repeated-addition algorithm (B iterations) or a shift-and-add algorithm (at most WIDTH iterations, with early termination). It sits between the operand source and any consumer that waits on a done pulse.

## Interface
- WIDTH, 16, operand width in bits (2..32); product is 2*WIDTH.
- clk  in  1  rising-edge clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = repeated-add, 1 = shift-add; sampled with start.
- a_in  in  WIDTH  multiplicand, sampled with start.
- b_in  in  WIDTH  multiplier, sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; product valid from this cycle on.
- product  out  2*WIDTH  result register, unsigned.

## Operation
- Reset values (rst high at an edge): state IDLE, busy 0, done 0, product 0, all internal registers 0. Reset takes priority over every other event, including mid-operation; the operation is abandoned with no done pulse.
- IDLE: start=1 at an edge loads the following values and moves to RUN:
  - a_reg <= zero-extended a_in (2*WIDTH bits);
  - b_reg <= b_in;
  - mode_reg <= mode;
  - product <= 0.
  start=0 keeps IDLE, and product holds the last result.
- RUN, repeated-add (mode_reg=0), at each edge:
  - if b_reg==0 or a_reg==0: go to DONE;
  - else: product <= product + a_reg, b_reg <= b_reg - 1.
- RUN, shift-add (mode_reg=1), at each edge:
  - if b_reg==0 or a_reg==0: go to DONE;
  - else: if b_reg[0], product <= product + a_reg; then a_reg <= a_reg << 1 and b_reg <= b_reg >> 1.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start in RUN or DONE is ignored and is not queued. The operands and mode may change freely while busy.
- Arithmetic is 2*WIDTH-bit unsigned and cannot overflow, since a*b < 2^(2*WIDTH). In shift-add, a_reg bits shifted past bit 2*WIDTH-1 are discarded; this is unreachable because b_reg is zero by then.
- Outputs are Moore: done = (state==DONE), busy = (state!=IDLE).

## Timing
- Counting from the edge that accepts start (edge 0), done is high in the cycle after edge N+1:
  - repeated-add: N = b_in, or 0 if either operand is 0;
  - shift-add: N = index of the highest set bit of b_in plus 1, or 0 if either operand is 0.
- Worst-case latency: repeated-add 2^WIDTH cycles; shift-add WIDTH+1 cycles.
- The earliest next start is accepted at the edge ending the DONE cycle + 1, i.e. the first IDLE cycle.
- product changes only at accepted-start edges (cleared) and RUN edges. It is stable during DONE and IDLE.

## Structure
- Package mul_pkg holds:
  - state type (IDLE, RUN, DONE);
  - mode constants MODE_REPADD=1'b0 and MODE_SHIFT=1'b1.
- One sub-module, mul_cntr: a loadable WIDTH-bit register with decrement and shift-right-by-one controls, plus a zero flag. It holds b_reg and drives the loop-termination test, in the same way as the team's load/decrement counter with equal-zero compare.
- Everything else (a_reg, product, adder, FSM) lives in seq_mul. There is a single adder instance, shared by both modes.

## Test plan
- WIDTH=16, mode=0, a=17, b=5, start pulsed -> busy at once; done in the cycle after edge 6; product=85; no further done pulses.
- mode=1, a=17, b=5 -> done in the cycle after edge 4; product=85. Then with a=65535, b=65535 -> done after edge 17; product=4294836225.
- Zero operands, mode=0 and mode=1: a=0, b=9 and a=9, b=0 -> done in the cycle after edge 1; product=0.
- During RUN (a=3, b=10, mode=0), pulse start with a=7, b=7 -> ignored; product=30 at done. Back-to-back start in the first IDLE cycle is accepted.
- rst asserted at edge 3 of a=17, b=5, mode=0 -> next cycle state IDLE, busy=0, product=0, and no done pulse. A new start after release yields the correct result.
- Randomised cross-check over 200 operand pairs in both modes: product == a*b, and latency matches the Timing formulas exactly.
